serial_job_sched: RTL and testbench

- Schedules operand jobs onto the single shared b01 serial line unit.
- The unit has one clock, serial inputs LINE1/LINE2 and registered outputs OUTP/OVERFLW.
- Two requesters submit W-bit operand pairs. The block arbitrates round-robin between them and shifts the granted pair LSB-first onto line1/line2.
- It collects the returned OUTP bits into a W-bit result, flags any OVERFLW pulse, and returns the result through a valid/ready response port tagged with the requester id.

---
 rtl/serial_sched_pkg.sv | 15 +
 rtl/serial_job_sched_rr_arb2.sv | 18 +
 rtl/serial_job_sched.sv | 147 ++++++++++++++
 tb/tb_serial_job_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types and constants for the serial line job scheduler.
package serial_sched_pkg;

  localparam int unsigned DEF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic id_t;

endpackage

// File: rtl/serial_job_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_job_sched.sv
// Feeds arbitrated operand pairs LSB-first to the shared serial unit and collects its OUTP
// stream into a tagged result returned over a valid/ready port.
module serial_job_sched
  import serial_sched_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ovf,
  output logic         line1,
  output logic         line2,
  input  logic         outp,
  input  logic         overflw,
  output logic         busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_b_sh;
  logic [W-1:0]  r_result;
  logic          r_ovf;
  id_t           r_id;
  logic          r_last_grant;
  logic          r_line1;
  logic          r_line2;

  logic [1:0]    w_grant;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_accept;
  id_t           w_acc_id;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_last;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign req0_ready = (r_state == ST_IDLE) & w_grant[0];
  assign req1_ready = (r_state == ST_IDLE) & w_grant[1];
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_accept   = w_acc0 | w_acc1;
  assign w_acc_id   = w_acc1;
  assign w_a        = w_acc1 ? req1_a : req0_a;
  assign w_b        = w_acc1 ? req1_b : req0_b;
  assign w_last     = (r_cnt == LAST);

  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_id    = r_id;
  assign rsp_data  = r_result;
  assign rsp_ovf   = r_ovf;
  assign line1     = r_line1;
  assign line2     = r_line2;
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  if (rsp_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // The serial unit registers its outputs, so OUTP for line bit i arrives one cycle
  // later: bit cnt-1 is captured during SHIFT and the final bit during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_line1      <= 1'b0;
      r_line2      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_line1      <= w_a[0];
            r_line2      <= w_b[0];
            r_a_sh       <= w_a >> 1;
            r_b_sh       <= w_b >> 1;
            r_id         <= w_acc_id;
            r_last_grant <= w_acc_id;
            r_cnt        <= '0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_result[r_cnt - CW'(1)] <= outp;
            r_ovf                    <= r_ovf | overflw;
          end
          if (w_last) begin
            r_line1 <= 1'b0;
            r_line2 <= 1'b0;
          end else begin
            r_line1 <= r_a_sh[0];
            r_line2 <= r_b_sh[0];
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          r_result[W-1] <= outp;
          r_ovf         <= r_ovf | overflw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_job_sched.sv
// Scoreboard bench for serial_job_sched with a delay stub and a b01 behavioural unit.
module tb_serial_job_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_data;
  logic         line1, line2, outp, overflw, busy;

  logic mode;      // 0: delay stub, 1: b01 unit
  logic ovf_drv;
  logic b01_rst;
  logic d_outp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;
  exp_t sb_q[$];

  serial_job_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .line1(line1), .line2(line2), .outp(outp), .overflw(overflw), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) d_outp <= line1;

  // b01 serial comparator, registered outputs
  typedef enum logic [2:0] {B_A, B_B, B_C, B_E, B_F, B_G, B_WF0, B_WF1} b01_t;
  b01_t b_st = B_A;
  logic b_outp = 1'b0;
  logic b_ovf = 1'b0;
  always @(posedge clk) begin
    if (b01_rst) begin
      b_st <= B_A; b_outp <= 1'b0; b_ovf <= 1'b0;
    end else begin
      b_ovf <= 1'b0;
      case (b_st)
        B_A:   begin b_st <= (line1 & line2) ? B_F : B_B;     b_outp <= line1 ^ line2; end
        B_E:   begin b_st <= (line1 & line2) ? B_F : B_B;     b_outp <= line1 ^ line2; b_ovf <= 1'b1; end
        B_B:   begin b_st <= (line1 & line2) ? B_G : B_C;     b_outp <= line1 ^ line2; end
        B_F:   begin b_st <= (line1 | line2) ? B_G : B_C;     b_outp <= ~(line1 ^ line2); end
        B_C:   begin b_st <= (line1 & line2) ? B_WF1 : B_WF0; b_outp <= line1 ^ line2; end
        B_G:   begin b_st <= (line1 | line2) ? B_WF1 : B_WF0; b_outp <= ~(line1 ^ line2); end
        B_WF0: begin b_st <= (line1 & line2) ? B_E : B_A;     b_outp <= line1 ^ line2; end
        default: begin b_st <= (line1 | line2) ? B_E : B_A;   b_outp <= ~(line1 ^ line2); end
      endcase
    end
  end

  assign outp    = mode ? b_outp : d_outp;
  assign overflw = mode ? b_ovf : ovf_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic id, input logic [W-1:0] d, input logic o);
    exp_t e;
    e.id = id; e.data = d; e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Returns after the accept edge (+1) with the accepted id and cycle stamp
  task automatic wait_accept(output logic id, output int t);
    bit got;
    got = 1'b0; id = 1'b0; t = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin got = 1'b1; id = 1'b0; end
      else if (req1_valid && req1_ready) begin got = 1'b1; id = 1'b1; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      t = cyc;
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("rsp_drain", 32'(sb_q.size()), 32'd0);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic job_ovf(input int pos, input logic e_ovf, input logic [W-1:0] a);
    logic id; int t;
    push(1'b0, a, e_ovf);
    if (pos < 0) begin ovf_drv = 1'b1; step(); ovf_drv = 1'b0; end
    req0_a = a; req0_b = ~a; req0_valid = 1'b1;
    wait_accept(id, t);
    req0_valid = 1'b0;
    for (int k = 0; k <= W + 1; k++) begin
      ovf_drv = (k == pos);
      step();
    end
    ovf_drv = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic id;
    int t, t_prev, hs;
    logic [W-1:0] exp_l1, exp_l2;

    rst_n = 1'b0; mode = 1'b0; ovf_drv = 1'b0; b01_rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    step(); step();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line1", 32'(line1), 32'd0);
    chk("rst_line2", 32'(line2), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: single job, line sequences and latency
    rsp_ready = 1'b1;
    exp_l1 = 8'b1010_0101;
    exp_l2 = 8'b0011_1100;
    push(1'b0, 8'hA5, 1'b0);
    req0_a = 8'hA5; req0_b = 8'h3C; req0_valid = 1'b1;
    wait_accept(id, t);
    req0_valid = 1'b0;
    chk("t1_id", 32'(id), 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("t1_line1", 32'(line1), 32'(exp_l1[i]));
      chk("t1_line2", 32'(line2), 32'(exp_l2[i]));
    end
    @(negedge clk);
    chk("t1_drain_valid", 32'(rsp_valid), 32'd0);
    chk("t1_drain_line1", 32'(line1), 32'd0);
    @(negedge clk);
    chk("t1_lat_valid", 32'(rsp_valid), 32'd1);
    wait_empty();

    // 2: both requesters continuously valid, grants alternate from reset
    do_reset();
    push(1'b0, 8'h12, 1'b0); push(1'b1, 8'hC3, 1'b0);
    push(1'b0, 8'h12, 1'b0); push(1'b1, 8'hC3, 1'b0);
    req0_a = 8'h12; req0_b = 8'h0F; req1_a = 8'hC3; req1_b = 8'hF0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    t_prev = 0;
    for (int j = 0; j < 4; j++) begin
      wait_accept(id, t);
      chk("t2_grant", 32'(id), 32'(j % 2));
      if (j > 0) chk("t2_spacing", 32'(t - t_prev), 32'd11);
      t_prev = t;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty();

    // 3: overflow capture window
    job_ovf(5, 1'b1, 8'h00);
    job_ovf(W, 1'b1, 8'hFF);
    job_ovf(0, 1'b0, 8'h81);
    job_ovf(-1, 1'b0, 8'h7E);
    wait_empty();

    // 4: back-pressure
    rsp_ready = 1'b0;
    push(1'b0, 8'h96, 1'b0);
    req0_a = 8'h96; req0_b = 8'h00; req0_valid = 1'b1;
    wait_accept(id, t);
    req0_a = 8'h69; req1_a = 8'h4B; req1_b = 8'h11; req1_valid = 1'b1;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_data", 32'(rsp_data), 32'h96);
      chk("t4_req0_ready", 32'(req0_ready), 32'd0);
      chk("t4_req1_ready", 32'(req1_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    push(1'b1, 8'h4B, 1'b0);
    push(1'b0, 8'h69, 1'b0);
    step();
    hs = cyc;
    chk("t4_one_handshake", 32'(rsp_valid), 32'd0);
    wait_accept(id, t);
    req1_valid = 1'b0;
    chk("t4_next_id", 32'(id), 32'd1);
    chk("t4_next_gap", 32'(t - hs), 32'd1);
    wait_accept(id, t);
    req0_valid = 1'b0;
    chk("t4_third_id", 32'(id), 32'd0);
    wait_empty();

    // 5: reset in the middle of SHIFT
    do_reset();
    req0_a = 8'hFF; req0_b = 8'hFF; req0_valid = 1'b1;
    wait_accept(id, t);
    req0_valid = 1'b0;
    step(); step(); step();
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_line1", 32'(line1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_line1", 32'(line1), 32'd0);
    chk("t5_line2", 32'(line2), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    req0_a = 8'h33; req0_b = 8'h00; req1_a = 8'hCC; req1_b = 8'h00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    push(1'b0, 8'h33, 1'b0);
    push(1'b1, 8'hCC, 1'b0);
    step();
    rst_n = 1'b1;
    wait_accept(id, t);
    req0_valid = 1'b0;
    chk("t5_first_grant", 32'(id), 32'd0);
    wait_accept(id, t);
    req1_valid = 1'b0;
    chk("t5_second_grant", 32'(id), 32'd1);
    wait_empty();

    // 6: b01 unit from its initial state, a=b=FF
    mode = 1'b1;
    b01_rst = 1'b1;
    push(1'b0, 8'hEE, 1'b1);
    req0_a = 8'hFF; req0_b = 8'hFF; req0_valid = 1'b1;
    wait_accept(id, t);
    b01_rst = 1'b0;
    req0_valid = 1'b0;
    wait_empty();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
